// File: rtl/lut_layer_sched.sv
// lut_layer_sched: time-multiplexed evaluator for one sparse LUT-neuron layer.
// Each neuron owns a 2^FANIN x 1 truth table and a fan-in map of FANIN
// indices into the activation vector. One neuron is evaluated per cycle.
// Build option: define LUT_LAYER_SCHED_PIPE_EN to insert a register stage
// between the address gather and the truth-table read (one extra drain cycle).
module lut_layer_sched #(
    parameter int IN_WIDTH = 64,
    parameter int NEURONS  = 16,
    parameter int FANIN    = 8,
    parameter int IDX_W    = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_WIDTH-1:0]             in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NEURONS-1:0]              out_data,
    input  logic                            cfg_we,
    input  logic                            cfg_sel,
    input  logic [$clog2(NEURONS)+FANIN-1:0] cfg_addr,
    input  logic [IDX_W-1:0]                cfg_wdata,
    output logic                            cfg_err
);

    localparam int NW    = $clog2(NEURONS);
    localparam int SW    = $clog2(FANIN);
    localparam int DEPTH = 1 << FANIN;
    localparam int CW    = $clog2(NEURONS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_n;
    logic [IN_WIDTH-1:0] r_vec;
    logic [NEURONS-1:0]  r_out;
    logic                r_cfg_err;
    logic [IDX_W-1:0]    r_map   [NEURONS][FANIN];
    logic [DEPTH-1:0]    r_truth [NEURONS];

    logic                w_in_hs;
    logic [NW-1:0]       w_cfg_neu;
    logic [FANIN-1:0]    w_cfg_fld;
    logic [SW-1:0]       w_cfg_slot;
    logic                w_cfg_ok;
    logic [NW-1:0]       w_eval_n;
    logic [FANIN-1:0]    w_addr;
    logic                w_bit;

    assign w_in_hs    = in_valid && in_ready;
    assign w_cfg_neu  = cfg_addr[NW+FANIN-1:FANIN];
    assign w_cfg_fld  = cfg_addr[FANIN-1:0];
    assign w_cfg_slot = cfg_addr[SW-1:0];
    assign w_eval_n   = r_n[NW-1:0];

    // A config write lands only in a quiet IDLE cycle with in-range fields;
    // a map entry must name an existing slot and an existing input bit.
    assign w_cfg_ok = cfg_we
                   && (r_state == S_IDLE)
                   && !w_in_hs
                   && (int'(w_cfg_neu) < NEURONS)
                   && (cfg_sel || ((int'(w_cfg_fld) < FANIN) && (int'(cfg_wdata) < IN_WIDTH)));

    // Gather the truth-table address of the neuron currently selected by r_n.
    always_comb begin
        w_addr = '0;
        for (int k = 0; k < FANIN; k++) begin
            w_addr[k] = r_vec[r_map[w_eval_n][k]];
        end
    end

`ifdef LUT_LAYER_SCHED_PIPE_EN
    logic [FANIN-1:0] r_addr_p1;
    logic [NW-1:0]    r_n_p1;
    logic             r_vld_p1;

    // gather -> read stage boundary: latch address and neuron index
    always_ff @(posedge clk) begin
        r_addr_p1 <= w_addr;
        r_n_p1    <= w_eval_n;
    end

    // Valid for the read stage; cleared by reset so an aborted vector leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= (r_state == S_EVAL) && (r_n < CW'(NEURONS));
        end
    end

    assign w_bit = r_truth[r_n_p1][r_addr_p1];
`else
    assign w_bit = r_truth[w_eval_n][w_addr];
`endif

    // Sequencer: IDLE accepts a vector, EVAL walks the neurons, DONE holds the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_hs) begin
                        r_state <= S_EVAL;
                        r_n     <= '0;
                    end
                end
                S_EVAL: begin
`ifdef LUT_LAYER_SCHED_PIPE_EN
                    // one extra drain cycle lets the last neuron leave the read stage
                    if (r_n == CW'(NEURONS)) begin
`else
                    if (r_n == CW'(NEURONS - 1)) begin
`endif
                        r_state <= S_DONE;
                        r_n     <= '0;
                    end else begin
                        r_n <= r_n + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_n     <= '0;
                end
            endcase
        end
    end

    // Activation vector capture on input handshake.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_vec <= in_data;
        end
    end

    // Result register: one neuron bit written per evaluation cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
`ifdef LUT_LAYER_SCHED_PIPE_EN
        end else if (r_vld_p1) begin
            r_out[r_n_p1] <= w_bit;
`else
        end else if (r_state == S_EVAL) begin
            r_out[w_eval_n] <= w_bit;
`endif
        end
    end

    // Programmable tables: fan-in maps and truth tables, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NEURONS; n++) begin
                r_truth[n] <= '0;
                for (int k = 0; k < FANIN; k++) begin
                    r_map[n][k] <= '0;
                end
            end
        end else if (w_cfg_ok) begin
            if (cfg_sel) begin
                r_truth[w_cfg_neu][w_cfg_fld] <= cfg_wdata[0];
            end else begin
                r_map[w_cfg_neu][w_cfg_slot] <= cfg_wdata;
            end
        end
    end

    // One-cycle error pulse for every rejected config write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_lut_layer_sched.sv
// Testbench for lut_layer_sched: directed scenarios plus randomized vectors and
// configuration, checked against a table-based reference of the layer.
module tb_lut_layer_sched;

    localparam int IN_WIDTH = 64;
    localparam int NEURONS  = 16;
    localparam int FANIN    = 8;
    localparam int IDX_W    = 6;
    localparam int AW       = $clog2(NEURONS) + FANIN;
    localparam int DEPTH    = 1 << FANIN;
`ifdef LUT_LAYER_SCHED_PIPE_EN
    localparam int EXP_LAT  = NEURONS + 2;
`else
    localparam int EXP_LAT  = NEURONS + 1;
`endif

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NEURONS-1:0]  out_data;
    logic                cfg_we;
    logic                cfg_sel;
    logic [AW-1:0]       cfg_addr;
    logic [IDX_W-1:0]    cfg_wdata;
    logic                cfg_err;

    int n_cmp;
    int n_mis;

    // reference tables
    int             mmap [NEURONS][FANIN];
    bit [DEPTH-1:0] tt   [NEURONS];

    lut_layer_sched #(
        .IN_WIDTH (IN_WIDTH),
        .NEURONS  (NEURONS),
        .FANIN    (FANIN),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NEURONS-1:0] golden(input logic [IN_WIDTH-1:0] v);
        logic [NEURONS-1:0] res;
        int a;
        res = '0;
        for (int n = 0; n < NEURONS; n++) begin
            a = 0;
            for (int k = 0; k < FANIN; k++) begin
                if (v[mmap[n][k]]) a += (1 << k);
            end
            res[n] = tt[n][a];
        end
        return res;
    endfunction

    task automatic model_clear();
        for (int n = 0; n < NEURONS; n++) begin
            tt[n] = '0;
            for (int k = 0; k < FANIN; k++) mmap[n][k] = 0;
        end
    endtask

    function automatic bit cfg_legal(input logic sel, input logic [AW-1:0] addr, input logic [IDX_W-1:0] wd);
        int neu;
        int fld;
        neu = int'(addr) / DEPTH;
        fld = int'(addr) % DEPTH;
        if (neu >= NEURONS) return 1'b0;
        if (!sel && (fld >= FANIN || int'(wd) >= IN_WIDTH)) return 1'b0;
        return 1'b1;
    endfunction

    // Config write from IDLE with no input handshake; starts and ends on a negedge.
    task automatic cfg_write(input logic sel, input logic [AW-1:0] addr, input logic [IDX_W-1:0] wd);
        bit ok;
        int neu;
        int fld;
        ok  = cfg_legal(sel, addr, wd);
        neu = int'(addr) / DEPTH;
        fld = int'(addr) % DEPTH;
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = wd;
        @(posedge clk);
        #1;
        chk("cfg_err_idle", cfg_err, !ok);
        if (ok) begin
            if (sel) tt[neu][fld] = wd[0];
            else     mmap[neu][fld] = int'(wd);
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Send one vector and retire its result; starts and ends on a negedge in IDLE.
    task automatic run_vec(input logic [IN_WIDTH-1:0] v, input bit bad_eval, input bit hs_cfg,
                           input int hold, input bit rand_iv);
        logic [NEURONS-1:0] exp;
        int  lat;
        bit  done;
        chk("in_ready_idle", in_ready, 1'b1);
        exp      = golden(v);
        in_valid = 1'b1;
        in_data  = v;
        if (hs_cfg) begin
            cfg_we    = 1'b1;
            cfg_sel   = 1'b1;
            cfg_addr  = AW'($urandom);
            cfg_wdata = IDX_W'($urandom);
        end
        @(posedge clk);
        #1;
        chk("cfg_err_hs", cfg_err, hs_cfg);
        chk("in_ready_accept", in_ready, 1'b0);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        cfg_we   = bad_eval;
        if (bad_eval) begin
            cfg_sel   = 1'b0;
            cfg_addr  = AW'($urandom_range(0, NEURONS - 1) * DEPTH + $urandom_range(0, FANIN - 1));
            cfg_wdata = IDX_W'($urandom_range(0, IN_WIDTH - 1));
        end
        done = 1'b0;
        while (!done && lat < 64) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 2) begin
                chk("cfg_err_eval", cfg_err, bad_eval);
                chk("in_ready_eval", in_ready, 1'b0);
            end
            if (out_valid) done = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0;
        end
        if (!done) begin
            chk("out_valid_timeout", out_valid, 1'b1);
            return;
        end
        chk("latency", lat, EXP_LAT);
        chk("out_data", out_data, exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = rand_iv ? 1'($urandom) : 1'b0;
            in_data   = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, exp);
            chk("hold_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("retire_valid", out_valid, 1'b0);
        chk("retire_in_ready", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        n_cmp     = 0;
        n_mis     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_sel   = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // all-ones vector against cleared tables
        run_vec({IN_WIDTH{1'b1}}, 1'b0, 1'b0, 0, 1'b0);

        // identity maps, truth 1 only at entry 0x03
        for (int n = 0; n < NEURONS; n++) begin
            for (int k = 0; k < FANIN; k++) begin
                a = AW'(n * DEPTH + k);
                cfg_write(1'b0, a, IDX_W'(k));
            end
            a = AW'(n * DEPTH + 3);
            cfg_write(1'b1, a, IDX_W'(1));
        end
        chk("golden_03", golden(64'h3), 16'hFFFF);
        chk("golden_07", golden(64'h7), 16'h0000);
        run_vec(64'h3, 1'b0, 1'b0, 0, 1'b0);
        run_vec(64'h7, 1'b0, 1'b0, 0, 1'b0);

        // long back-pressure in DONE
        run_vec(64'h3, 1'b0, 1'b0, 20, 1'b1);

        // rejected writes: during EVAL, with the input handshake, bad map slot
        run_vec(64'h3, 1'b1, 1'b0, 1, 1'b0);
        run_vec(64'h3, 1'b0, 1'b1, 1, 1'b0);
        cfg_write(1'b0, AW'(2 * DEPTH + 9), IDX_W'(5));
        cfg_write(1'b0, AW'(5 * DEPTH + 200), IDX_W'(63));
        run_vec(64'h3, 1'b0, 1'b0, 0, 1'b0);
        run_vec(64'hFFFF_0000_0000_0003, 1'b0, 1'b0, 0, 1'b0);

        // reset in the middle of EVAL
        for (int n = 0; n < NEURONS; n++) cfg_write(1'b1, AW'(n * DEPTH + 255), IDX_W'(1));
        in_valid = 1'b1;
        in_data  = {IN_WIDTH{1'b1}};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_data", out_data, '0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", out_valid, 1'b0);
        end
        @(negedge clk);
        run_vec({IN_WIDTH{1'b1}}, 1'b0, 1'b0, 0, 1'b0);
        cfg_write(1'b1, AW'(255), IDX_W'(1));
        run_vec(64'h3, 1'b0, 1'b0, 0, 1'b0);

        // random fill of all tables
        for (int n = 0; n < NEURONS; n++) begin
            for (int k = 0; k < FANIN; k++)
                cfg_write(1'b0, AW'(n * DEPTH + k), IDX_W'($urandom_range(0, IN_WIDTH - 1)));
            for (int e = 0; e < DEPTH; e++)
                cfg_write(1'b1, AW'(n * DEPTH + e), IDX_W'($urandom));
        end

        // random vectors mixed with random config traffic
        for (int it = 0; it < 1000; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                logic sel;
                int   fld;
                sel = 1'($urandom);
                if (sel) fld = $urandom_range(0, DEPTH - 1);
                else if ($urandom_range(0, 7) == 0) fld = $urandom_range(FANIN, DEPTH - 1);
                else fld = $urandom_range(0, FANIN - 1);
                cfg_write(sel, AW'($urandom_range(0, NEURONS - 1) * DEPTH + fld), IDX_W'($urandom));
            end
            run_vec({$urandom, $urandom}, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
